mem_arbiter: RTL
================

# mem_arbiter

Two-port arbiter that shares the single-port `memory` (synchronous write, one-cycle registered read) between the `cpu` (port 0) and an auxiliary requester (port 1, e.g. a loader or debug/DMA engine). It sits between both masters and `memory`, issues at most one memory access per cycle, and routes read data back to the issuing port. Arbitration is round-robin with a bounded burst, so neither port starves.

## Interface
- `ADDR_WIDTH`, 6, memory address width
- `DATA_WIDTH`, 16, memory data width
- `BURST`, 4, max consecutive grants to one port while the other is requesting (≥1)

- `clk`  in  1  system clock; all state updates on rising edge
- `rst_n`  in  1  reset: synchronous, active-low
- `req0`, `req1`  in  1  access request, ports 0/1
- `we0`, `we1`  in  1  1 = write, 0 = read
- `addr0`, `addr1`  in  ADDR_WIDTH  access address
- `wdata0`, `wdata1`  in  DATA_WIDTH  write data
- `gnt0`, `gnt1`  out  1  access accepted this cycle (combinational)
- `rvalid0`, `rvalid1`  out  1  read data valid pulse (registered)
- `rdata0`, `rdata1`  out  DATA_WIDTH  read data (registered)
- `mem_we`  out  1  to `memory.we`
- `mem_addr`  out  ADDR_WIDTH  to `memory.addr`
- `mem_data`  out  DATA_WIDTH  to `memory.data`
- `mem_in`  in  DATA_WIDTH  from `memory.out`

## Operation
- Internal state: `last_grant` (1 b), `granted_prev` (1 b), `cnt` (0..BURST), `rd_pend` (1 b), `rd_port` (1 b).
- Grant selection, evaluated every cycle:
  - Neither requests: no grant.
  - Exactly one requests: grant it.
  - Both request:
    - If `granted_prev` and `cnt < BURST`: grant `last_grant`.
    - Otherwise grant `~last_grant`.
- Exactly one of `gnt0`/`gnt1` is high when any request is pending. Both are never high together.
- Memory bus is a combinational mux of the granted port's `we/addr/wdata`.
  - With no grant: `mem_we=0`, `mem_addr=0`, `mem_data=0`.
- State update on each grant to port p:
  - If `granted_prev` and p==`last_grant`: `cnt <= min(cnt+1, BURST)`; else `cnt <= 1`.
  - `last_grant <= p`; `granted_prev <= 1`.
- No grant: `granted_prev <= 0`; `cnt` and `last_grant` hold.
- Granted read: `rd_pend <= 1`, `rd_port <= p`. Otherwise `rd_pend <= 0`.
- Response routing: when `rd_pend`, `rvalid[rd_port]=1` and `rdata[rd_port]=mem_in`, sampled from `memory`'s registered output. The other port's rdata holds.
- Granted writes produce no rvalid.
- Requester handshake: hold `req/we/addr/wdata` stable until a rising edge with `gnt` high. The transfer completes on that edge. To issue the next access, keep `req` high with new fields.

## Timing
- Reset values (`rst_n=0` at edge): `last_grant=1` (port 0 wins the first tie), `granted_prev=0`, `cnt=0`, `rd_pend=0`, `rvalid0/1=0`, `rdata0/1=0`.
- While `rst_n=0`: `gnt0/1` and `mem_we` are forced 0, so reset blocks all grants and writes.
- Grant latency: 0 cycles (same cycle as `req`).
- Write: commits at the edge ending the grant cycle.
- Read: `rvalid` high in cycle N+1 for a grant in cycle N. Throughput is 1 access per cycle.
- Back-to-back reads from alternating ports return in grant order, one per cycle.
- Reset mid-read: a pending `rvalid` is dropped.
- Request withdrawn before grant: legal, no side effect.
- `BURST=1` degenerates to strict alternation under contention.

## Structure
- Shared package `mem_arbiter_pkg`: `PORT_CPU=0`, `PORT_AUX=1`, default `BURST`, and the `cnt` width function (`$clog2(BURST+1)`).
- One sub-module `rr_select`: pure combinational winner pick from (`req0`, `req1`, `last_grant`, `granted_prev`, `cnt`, `BURST`).
- Burst counter, read-return registers and muxes stay in `mem_arbiter`.

## Test plan
- Reset then solo CPU: `req0=1`, `we0=0`, `addr0=5`, with `mem[5]=16'h1234`. Expect `gnt0` in the same cycle, `rvalid0=1` and `rdata0=16'h1234` in the next cycle, and `rvalid1=0`.
- Both request from idle right after reset, `BURST=4`, held for 10 cycles. Expect grant sequence 0,0,0,0,1,1,1,1,0,0.
- `BURST=1`, both ports reading continuously (`addr0=1`, `addr1=2`). Expect alternating grants, and `rvalid0`/`rvalid1` alternating one cycle behind with correct data.
- Port 1 writes `16'hBEEF` to `addr=7`, then port 0 reads `addr=7` on the next cycle. Expect `rdata0=16'hBEEF`, and no `rvalid1` for the write.
- Assert `rst_n=0` in the cycle after a port-1 read grant. Expect `rvalid1=0`, `gnt0/1=0` and `mem_we=0` during reset. After release, a tie grants port 0.
- Port 0 alone for 6 cycles, then port 1 joins. Expect port 1 granted on the first contended cycle, because `cnt` is saturated.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared constants for the two-port memory arbiter.
//   PORT_CPU / PORT_AUX   port indices used for last_grant / rd_port
//   *_DEF                 default parameter values
//   cnt_width()           width of the burst counter holding 0..BURST
package mem_arbiter_pkg;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_AUX = 1'b1;

    localparam int ADDR_WIDTH_DEF = 6;
    localparam int DATA_WIDTH_DEF = 16;
    localparam int BURST_DEF      = 4;

    function automatic int cnt_width(input int burst);
        return $clog2(burst + 1);
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundle of both requester ports plus the memory bus.
//   req*/we*/addr*/wdata*     requester -> arbiter
//   gnt*/rvalid*/rdata*       arbiter -> requester
//   mem_we/mem_addr/mem_data  arbiter -> memory
//   mem_in                    memory registered read data -> arbiter
// slave  : the arbiter's view.
// master : the environment's view (both requesters and the memory).
interface mem_arbiter_if #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 16
);
    logic                  req0,   req1;
    logic                  we0,    we1;
    logic [ADDR_WIDTH-1:0] addr0,  addr1;
    logic [DATA_WIDTH-1:0] wdata0, wdata1;
    logic                  gnt0,   gnt1;
    logic                  rvalid0, rvalid1;
    logic [DATA_WIDTH-1:0] rdata0, rdata1;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_data;
    logic [DATA_WIDTH-1:0] mem_in;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_in,
        output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
               mem_we, mem_addr, mem_data
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_in,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
               mem_we, mem_addr, mem_data
    );
endinterface

// File: rtl/mem_arbiter_rr_select.sv
// rr_select: combinational winner pick for the two-port arbiter.
//   req0/req1     requests
//   last_grant    port granted most recently
//   granted_prev  a grant was issued in the previous cycle
//   cnt           consecutive grants to last_grant (saturates at BURST)
//   gnt0/gnt1     one-hot winner, both low when nobody requests
module rr_select
    import mem_arbiter_pkg::*;
#(
    parameter int BURST = BURST_DEF,
    parameter int CNT_W = cnt_width(BURST)
) (
    input  logic             req0,
    input  logic             req1,
    input  logic             last_grant,
    input  logic             granted_prev,
    input  logic [CNT_W-1:0] cnt,
    output logic             gnt0,
    output logic             gnt1
);
    logic keep;
    logic win;

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        // The current owner keeps the bus under contention only while its
        // run is unbroken and still short of BURST.
        keep = granted_prev && (cnt < CNT_W'(BURST));
        win  = keep ? last_grant : ~last_grant;
        case ({req1, req0})
            2'b01:   gnt0 = 1'b1;
            2'b10:   gnt1 = 1'b1;
            2'b11: begin
                gnt0 = ~win;
                gnt1 = win;
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares a single-port memory (sync write, 1-cycle registered
// read) between port 0 (cpu) and port 1 (aux). Round-robin with a bounded
// burst, zero-latency grant, read data routed back one cycle later.
//   clk    system clock
//   rst_n  synchronous active-low reset
//   bus    mem_arbiter_if.slave: both request ports and the memory bus
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int BURST      = BURST_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    mem_arbiter_if.slave  bus
);
    localparam int CNT_W = cnt_width(BURST);

    logic             last_grant;
    logic             granted_prev;
    logic [CNT_W-1:0] cnt;
    logic             rd_pend;
    logic             rd_port;

    logic                       sel0, sel1;
    logic [1:0]                 gnt;
    logic                       gnt_any;
    logic                       gnt_port;
    logic [1:0]                 we_p;
    logic [1:0][ADDR_WIDTH-1:0] addr_p;
    logic [1:0][DATA_WIDTH-1:0] wdata_p;
    logic                       mem_we_c;
    logic [ADDR_WIDTH-1:0]      mem_addr_c;
    logic [DATA_WIDTH-1:0]      mem_data_c;
    logic [1:0]                 rvalid;
    logic [1:0][DATA_WIDTH-1:0] rdata_q;
    logic [1:0][DATA_WIDTH-1:0] rdata;

    rr_select #(.BURST(BURST), .CNT_W(CNT_W)) u_sel (
        .req0         (bus.req0),
        .req1         (bus.req1),
        .last_grant   (last_grant),
        .granted_prev (granted_prev),
        .cnt          (cnt),
        .gnt0         (sel0),
        .gnt1         (sel1)
    );

    // Reset masks grants, which in turn keeps mem_we low.
    assign gnt      = {sel1 & rst_n, sel0 & rst_n};
    assign gnt_any  = |gnt;
    assign gnt_port = gnt[1];

    assign we_p    = {bus.we1, bus.we0};
    assign addr_p  = {bus.addr1, bus.addr0};
    assign wdata_p = {bus.wdata1, bus.wdata0};

    always_comb begin
        mem_we_c   = 1'b0;
        mem_addr_c = '0;
        mem_data_c = '0;
        if (gnt_any) begin
            mem_we_c   = we_p[gnt_port];
            mem_addr_c = addr_p[gnt_port];
            mem_data_c = wdata_p[gnt_port];
        end
    end

    // Arbitration state and read tracking.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_grant   <= PORT_AUX;   // port 0 wins the first tie
            granted_prev <= 1'b0;
            cnt          <= '0;
            rd_pend      <= 1'b0;
            rd_port      <= PORT_CPU;
        end else if (gnt_any) begin
            if (granted_prev && (gnt_port == last_grant))
                cnt <= (cnt == CNT_W'(BURST)) ? cnt : cnt + 1'b1;
            else
                cnt <= CNT_W'(1);
            last_grant   <= gnt_port;
            granted_prev <= 1'b1;
            rd_pend      <= ~we_p[gnt_port];
            rd_port      <= gnt_port;
        end else begin
            granted_prev <= 1'b0;
            rd_pend      <= 1'b0;
        end
    end

    // rvalid is decoded from registered state; gating with rst_n drops a
    // read that was in flight when reset arrived.
    assign rvalid[0] = rst_n & rd_pend & (rd_port == PORT_CPU);
    assign rvalid[1] = rst_n & rd_pend & (rd_port == PORT_AUX);

    // mem_in is already the memory's registered output, so it is passed
    // straight through in the rvalid cycle and captured to hold afterwards.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else begin
            for (int p = 0; p < 2; p++)
                if (rvalid[p]) rdata_q[p] <= bus.mem_in;
        end
    end

    always_comb begin
        for (int p = 0; p < 2; p++)
            rdata[p] = rvalid[p] ? bus.mem_in : rdata_q[p];
    end

    assign bus.gnt0     = gnt[0];
    assign bus.gnt1     = gnt[1];
    assign bus.rvalid0  = rvalid[0];
    assign bus.rvalid1  = rvalid[1];
    assign bus.rdata0   = rdata[0];
    assign bus.rdata1   = rdata[1];
    assign bus.mem_we   = mem_we_c;
    assign bus.mem_addr = mem_addr_c;
    assign bus.mem_data = mem_data_c;
endmodule
